// File: rtl/sp_ram_arb_2x32.sv
// sp_ram_arb_2x32 -- round-robin arbiter/sequencer sharing one single-port
// 32-bit RAM (sync_sp_ram_be_nx32) between two requesters.
//
// Ports:
//   Clk_CI, Rst_RI           clock, async active-high reset
//   Req_SI/Lock_SI/WrEn_SI   per-requester request, lock hint, write enable
//   BEn_SI/WrData_DI/Addr_DI per-requester byte enables, write data, address
//   Gnt_SO                   combinational one-hot (or zero) grant
//   RValid_SO/RdData_DO      per-requester response pulse and read data
//   Ram*_SO/_DO, RamRdData_DI RAM port
//
// A grant pushes {valid,id} into an L-deep shift register (L = 1+OUT_REGS),
// so the response pulse lines up with the RAM's read data.

// Per-requester slice: gates the payload with its grant (the top ORs the
// slices together) and decodes its own response pulse.
module sp_ram_arb_2x32_lane #(
  parameter int ADDR_WIDTH = 10,
  parameter int LANE       = 0
) (
  input  logic                  gnt_i,
  input  logic                  wr_en_i,
  input  logic [3:0]            ben_i,
  input  logic [31:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  rsp_vld_i,
  input  logic                  rsp_id_i,
  output logic                  wr_en_o,
  output logic [3:0]            ben_o,
  output logic [31:0]           wdata_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rvalid_o
);
  assign wr_en_o  = gnt_i & wr_en_i;
  assign ben_o    = {4{gnt_i}} & ben_i;
  assign wdata_o  = {32{gnt_i}} & wdata_i;
  assign addr_o   = {ADDR_WIDTH{gnt_i}} & addr_i;
  assign rvalid_o = rsp_vld_i & (rsp_id_i == 1'(LANE));
endmodule

module sp_ram_arb_2x32 #(
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REGS   = 0,
  parameter int MAX_LOCK   = 4
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RI,
  input  logic [1:0]                 Req_SI,
  input  logic [1:0]                 Lock_SI,
  input  logic [1:0]                 WrEn_SI,
  input  logic [1:0][3:0]            BEn_SI,
  input  logic [1:0][31:0]           WrData_DI,
  input  logic [1:0][ADDR_WIDTH-1:0] Addr_DI,
  output logic [1:0]                 Gnt_SO,
  output logic [1:0]                 RValid_SO,
  output logic [1:0][31:0]           RdData_DO,
  output logic                       RamCSel_SO,
  output logic                       RamWrEn_SO,
  output logic [3:0]                 RamBEn_SO,
  output logic [31:0]                RamWrData_DO,
  output logic [ADDR_WIDTH-1:0]      RamAddr_DO,
  input  logic [31:0]                RamRdData_DI
);
  localparam int L  = 1 + OUT_REGS;
  localparam int CW = $clog2(MAX_LOCK) + 1;

  logic          prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic [L:1]    vld_pipe_q, vld_pipe_d;
  logic [L:1]    id_pipe_q, id_pipe_d;
  logic [1:0]    gnt;
  logic          xfer, gid;

  // Grant is held off during reset so nothing reaches the RAM.
  always_comb begin
    gnt = '0;
    if (!Rst_RI) begin
      case (Req_SI)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt[prio_q] = 1'b1;
        default: gnt = '0;
      endcase
    end
  end

  assign xfer   = |gnt;
  assign gid    = gnt[1];
  assign Gnt_SO = gnt;

  // Locked requester keeps priority until MAX_LOCK transfers; any idle
  // cycle drops the lock count so a lock never outlives a gap.
  always_comb begin
    prio_d     = prio_q;
    lock_cnt_d = '0;
    if (xfer) begin
      if (Lock_SI[gid] && (lock_cnt_q < CW'(MAX_LOCK - 1))) begin
        prio_d     = gid;
        lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
        prio_d     = ~gid;
        lock_cnt_d = '0;
      end
    end
  end

  always_comb begin
    vld_pipe_d    = '0;
    id_pipe_d     = '0;
    vld_pipe_d[1] = xfer;
    id_pipe_d[1]  = gid;
    for (int k = 2; k <= L; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      id_pipe_d[k]  = id_pipe_q[k-1];
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      prio_q     <= 1'b0;
      lock_cnt_q <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_cnt_q <= lock_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  logic [1:0]                 lane_wr_en;
  logic [1:0][3:0]            lane_ben;
  logic [1:0][31:0]           lane_wdata;
  logic [1:0][ADDR_WIDTH-1:0] lane_addr;

  for (genvar i = 0; i < 2; i++) begin : g_lane
    sp_ram_arb_2x32_lane #(.ADDR_WIDTH(ADDR_WIDTH), .LANE(i)) u_lane (
      .gnt_i     (gnt[i]),
      .wr_en_i   (WrEn_SI[i]),
      .ben_i     (BEn_SI[i]),
      .wdata_i   (WrData_DI[i]),
      .addr_i    (Addr_DI[i]),
      .rsp_vld_i (vld_pipe_q[L]),
      .rsp_id_i  (id_pipe_q[L]),
      .wr_en_o   (lane_wr_en[i]),
      .ben_o     (lane_ben[i]),
      .wdata_o   (lane_wdata[i]),
      .addr_o    (lane_addr[i]),
      .rvalid_o  (RValid_SO[i])
    );
  end

  // Grant is one-hot, so OR-ing the gated slices is the payload mux.
  assign RamCSel_SO   = xfer;
  assign RamWrEn_SO   = |lane_wr_en;
  assign RamBEn_SO    = lane_ben[0] | lane_ben[1];
  assign RamWrData_DO = lane_wdata[0] | lane_wdata[1];
  assign RamAddr_DO   = lane_addr[0] | lane_addr[1];
  assign RdData_DO    = {2{RamRdData_DI}};
endmodule

// File: tb/tb_sp_ram_arb_2x32.sv
module tb_sp_ram_arb_2x32;
  localparam int AW = 10;
  localparam int OR = 1;
  localparam int L  = 1 + OR;
  localparam int ML = 4;

  logic                Clk_CI = 1'b0;
  logic                Rst_RI;
  logic [1:0]          Req_SI, Lock_SI, WrEn_SI;
  logic [1:0][3:0]     BEn_SI;
  logic [1:0][31:0]    WrData_DI;
  logic [1:0][AW-1:0]  Addr_DI;
  logic [1:0]          Gnt_SO, RValid_SO;
  logic [1:0][31:0]    RdData_DO;
  logic                RamCSel_SO, RamWrEn_SO;
  logic [3:0]          RamBEn_SO;
  logic [31:0]         RamWrData_DO;
  logic [AW-1:0]       RamAddr_DO;
  logic [31:0]         RamRdData_DI;

  sp_ram_arb_2x32 #(.ADDR_WIDTH(AW), .OUT_REGS(OR), .MAX_LOCK(ML)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI), .Req_SI(Req_SI), .Lock_SI(Lock_SI),
    .WrEn_SI(WrEn_SI), .BEn_SI(BEn_SI), .WrData_DI(WrData_DI), .Addr_DI(Addr_DI),
    .Gnt_SO(Gnt_SO), .RValid_SO(RValid_SO), .RdData_DO(RdData_DO),
    .RamCSel_SO(RamCSel_SO), .RamWrEn_SO(RamWrEn_SO), .RamBEn_SO(RamBEn_SO),
    .RamWrData_DO(RamWrData_DO), .RamAddr_DO(RamAddr_DO), .RamRdData_DI(RamRdData_DI)
  );

  always #5 Clk_CI = ~Clk_CI;

  int cyc = 0;
  always @(posedge Clk_CI) cyc <= cyc + 1;

  // Read-first RAM with one output register stage (OUT_REGS=1).
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rd1 = '0, rd2 = '0;
  always @(posedge Clk_CI) begin
    if (RamCSel_SO) begin
      rd1 <= mem[RamAddr_DO];
      if (RamWrEn_SO)
        for (int b = 0; b < 4; b++)
          if (RamBEn_SO[b]) mem[RamAddr_DO][8*b +: 8] <= RamWrData_DO[8*b +: 8];
    end
    rd2 <= rd1;
  end
  assign RamRdData_DI = rd2;

  typedef struct {
    logic               rst;
    logic [1:0]         req, lock, wren;
    logic [1:0][3:0]    ben;
    logic [1:0][31:0]   wd;
    logic [1:0][AW-1:0] addr;
    logic [1:0]         exp_gnt;
  } vec_t;

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] shadow [0:(1<<AW)-1];
  int          checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.rst = 1'b0; v.req = '0; v.lock = '0; v.wren = '0;
    v.ben = '0; v.wd = '0; v.addr = '0; v.exp_gnt = '0;
    return v;
  endfunction

  function automatic vec_t one(input int i, input logic wr, input int a,
                               input logic [31:0] d, input logic [3:0] be);
    vec_t v = idle();
    v.req[i] = 1'b1; v.wren[i] = wr; v.addr[i] = AW'(a);
    v.wd[i] = d; v.ben[i] = be; v.exp_gnt[i] = 1'b1;
    return v;
  endfunction

  function automatic vec_t both(input logic [1:0] lk, input logic [1:0] eg);
    vec_t v = idle();
    v.req = 2'b11; v.lock = lk; v.addr[0] = AW'(0); v.addr[1] = AW'(1);
    v.exp_gnt = eg;
    return v;
  endfunction

  function automatic vec_t in_rst();
    vec_t v = idle();
    v.rst = 1'b1; v.req = 2'b11;
    return v;
  endfunction

  // One cycle: drive after the edge, check at the falling edge, record the
  // expected response of any transfer the vector predicts.
  task automatic step(input vec_t v);
    logic [1:0] exp_rv;
    logic       g;
    int         a;
    rsp_t       e;
    @(posedge Clk_CI); #1;
    Rst_RI = v.rst; Req_SI = v.req; Lock_SI = v.lock; WrEn_SI = v.wren;
    BEn_SI = v.ben; WrData_DI = v.wd; Addr_DI = v.addr;
    if (v.rst) sb.delete();
    @(negedge Clk_CI);
    exp_rv = '0;
    if (sb.size() > 0 && sb[0].due == cyc) exp_rv[sb[0].id] = 1'b1;
    chk("rvalid", 32'(RValid_SO), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      chk("rdata", RdData_DO[sb[0].id], sb[0].data);
      void'(sb.pop_front());
    end
    chk("gnt", 32'(Gnt_SO), 32'(v.exp_gnt));
    chk("csel", 32'(RamCSel_SO), 32'(|v.exp_gnt));
    if (v.exp_gnt != 2'b00) begin
      g = v.exp_gnt[1];
      chk("ram_addr", 32'(RamAddr_DO), 32'(v.addr[g]));
      chk("ram_wren", 32'(RamWrEn_SO), 32'(v.wren[g]));
      if (v.wren[g]) begin
        chk("ram_ben", 32'(RamBEn_SO), 32'(v.ben[g]));
        chk("ram_wdata", RamWrData_DO, v.wd[g]);
      end
      a = int'(v.addr[g]);
      e.due = cyc + L; e.id = g; e.data = shadow[a];
      sb.push_back(e);
      if (v.wren[g])
        for (int b = 0; b < 4; b++)
          if (v.ben[g][b]) shadow[a][8*b +: 8] = v.wd[g][8*b +: 8];
    end else begin
      chk("ram_idle", 32'(RamAddr_DO) | RamWrData_DO | 32'(RamBEn_SO) | 32'(RamWrEn_SO), 32'h0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    for (int k = 0; k < (1<<AW); k++) begin mem[k] = '0; shadow[k] = '0; end
    Rst_RI = 1'b1; Req_SI = '0; Lock_SI = '0; WrEn_SI = '0;
    BEn_SI = '0; WrData_DI = '0; Addr_DI = '0;

    // reset: no grant even with both requesting
    repeat (3) vecs.push_back(in_rst());
    // contention from reset: strict alternation starting at req0
    for (int k = 0; k < 6; k++) vecs.push_back(both(2'b00, (k % 2 == 0) ? 2'b01 : 2'b10));
    repeat (3) vecs.push_back(idle());
    // single requester write then read back
    vecs.push_back(one(0, 1'b1, 5, 32'hDEADBEEF, 4'hF));
    vecs.push_back(one(0, 1'b0, 5, 32'h0, 4'h0));
    repeat (3) vecs.push_back(idle());
    // byte enables on req1: read returns 0x11BB33DD
    vecs.push_back(one(1, 1'b1, 3, 32'h11223344, 4'hF));
    vecs.push_back(one(1, 1'b1, 3, 32'hAABBCCDD, 4'h5));
    vecs.push_back(one(1, 1'b0, 3, 32'h0, 4'h0));
    repeat (3) vecs.push_back(idle());
    // lock bound: 4 locked grants to req0, then req1, then req0
    repeat (4) vecs.push_back(both(2'b01, 2'b01));
    vecs.push_back(both(2'b01, 2'b10));
    vecs.push_back(both(2'b01, 2'b01));
    repeat (3) vecs.push_back(idle());
    // idle, then a lone write whose ack arrives L cycles later
    vecs.push_back(one(0, 1'b1, 7, 32'hCAFEF00D, 4'hF));
    repeat (3) vecs.push_back(idle());

    foreach (vecs[k]) step(vecs[k]);

    // reset mid-flight: read grant to req0 (prio moves to 1), reset next
    // cycle drops the response and returns priority to req0
    step(one(0, 1'b0, 5, 32'h0, 4'h0));
    step(in_rst());
    step(in_rst());
    step(both(2'b00, 2'b01));
    step(both(2'b00, 2'b10));

    for (int k = 0; k < 8 && sb.size() > 0; k++) step(idle());
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    repeat (2) step(idle());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_ram_arb_2x32.md
# sp_ram_arb_2x32

Two-requester arbiter and sequencer for one `sync_sp_ram_be_nx32` instance. It shares the single RAM port between two masters, for example a core data port and a DMA/debug port. Arbitration is round-robin, with an optional bounded lock for atomic read-modify-write sequences. The block routes each read response back to the requester that issued the access, after the RAM's fixed latency.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width; must match the RAM instance.
- OUT_REGS, 0, must equal the RAM's OUT_REGS; read latency L = 1 + OUT_REGS.
- MAX_LOCK, 4, maximum consecutive locked grants to one requester (≥1).

Ports (index i ∈ {0,1}; arrays are packed, [1:0] outermost):
- Clk_CI  in  1  clock; the only clock.
- Rst_RI  in  1  reset; asynchronous, active-high.
- Req_SI  in  [1:0]  access request per requester.
- Lock_SI  in  [1:0]  keep grant for the next access (qualified by Req_SI).
- WrEn_SI  in  [1:0]  1 = write, 0 = read.
- BEn_SI  in  [1:0][3:0]  byte enables for writes.
- WrData_DI  in  [1:0][31:0]  write data.
- Addr_DI  in  [1:0][ADDR_WIDTH-1:0]  word address.
- Gnt_SO  out  [1:0]  grant; one-hot or zero.
- RValid_SO  out  [1:0]  response valid; one pulse per granted access.
- RdData_DO  out  [1:0][31:0]  read data, qualified by RValid_SO.
- RamCSel_SO  out  1  RAM chip select.
- RamWrEn_SO  out  1  RAM write enable.
- RamBEn_SO  out  4  RAM byte enables.
- RamWrData_DO  out  32  RAM write data.
- RamAddr_DO  out  ADDR_WIDTH  RAM address.
- RamRdData_DI  in  32  RAM read data.

The RAM's active-low reset is driven with ~Rst_RI at the level above this block.

## Operation
- **Handshake.** An access is transferred in any cycle where Req_SI[i] & Gnt_SO[i] = 1.
  - The requester holds Req_SI and its payload stable until granted.
  - Req_SI may be deasserted only after a transfer.
- **Grant (combinational from Req_SI and state).**
  - Exactly one requester active: it is granted.
  - Both active: the requester at the priority pointer Prio_SP is granted.
  - Neither active: Gnt_SO = 0 and RamCSel_SO = 0.
- **RAM drive.** RamCSel_SO = |Gnt_SO. Ram* outputs carry the granted requester's WrEn, BEn, WrData and Addr. With no grant, the payload outputs are 0.
- **Pointer update** (registered, only on a transfer by requester g):
  - Lock_SI[g] = 1 and LockCnt_SP < MAX_LOCK-1: Prio_SP := g and LockCnt_SP increments.
  - Otherwise: Prio_SP := ~g and LockCnt_SP := 0.
  - No transfer: Prio_SP holds and LockCnt_SP := 0. This releases the lock when the locked requester idles a cycle.
- **Lock bound.** A requester holding the lock gets at most MAX_LOCK consecutive transfers while the other requester waits; the waiting requester is served next.
- **Response tracking.**
  - An L-deep shift register of {valid, id} records each transfer.
  - At depth L, RValid_SO[id] pulses for one cycle.
  - Writes also produce a response pulse, acting as a write ack. RdData_DO on a write response is the pre-write word, since the RAM is read-first.
- **Read data.** RdData_DO[0] = RdData_DO[1] = RamRdData_DI unconditionally. Only RValid_SO qualifies the data.

## Timing
- **Reset values:** Prio_SP = 0, LockCnt_SP = 0, tracking pipeline all invalid, RValid_SO = 0.
  - Gnt_SO and RamCSel_SO are 0 whenever Req_SI = 0.
  - While Rst_RI = 1, Gnt_SO = 0 regardless of Req_SI.
- **Throughput and latency:**
  - Throughput is one access per cycle with no bubbles between requesters.
  - Grant-to-RValid latency is exactly L cycles: a grant at edge n gives RValid at cycle n+L.
- **Paths:** Req → Gnt and Req → Ram* are combinational. Requesters must not derive Req_SI combinationally from Gnt_SO.
- **Simultaneous events:** a new transfer and an emerging response in the same cycle are independent; both happen.
- **Reset mid-operation:** in-flight responses are discarded, no RValid is produced after reset, and the lock is released.
- **Wrap-around:** LockCnt_SP width is clog2(MAX_LOCK)+1 bits and saturates at MAX_LOCK-1; it never wraps.

## Test plan
- **Single requester:** req0 writes 0xDEADBEEF with BEn=0xF at addr 5, then reads addr 5. Expected: Gnt0 in the same cycle as each request, RValid0 L cycles after each grant, read data 0xDEADBEEF, RValid1 never set.
- **Contention round-robin:** both requesters issue continuous reads from reset. Expected grants 0,1,0,1…; each RValid id matches its grant id, delayed by exactly L cycles.
- **Byte enables:** req1 writes 0x11223344 to addr 3, then writes 0xAABBCCDD with BEn=0x5, then reads addr 3. Expected read data 0x11BB33DD.
- **Lock bound (MAX_LOCK=4):** req0 holds Lock with continuous requests while req1 requests. Expected: req0 granted 4 consecutive times, then req1 granted, then req0 again.
- **Reset mid-flight (OUT_REGS=1):** assert Rst_RI one cycle after a read grant. Expected: no RValid pulse, Gnt=0 during reset, first grant after reset goes to req0 when both request.
- **Idle and ack:** with no requests, RamCSel stays 0. A single write with OUT_REGS=1 produces an RValid pulse exactly 2 cycles after the grant.
